// File: rtl/is_msg_tx.sv
// is_msg_tx: transmit-side message sequencer for the UART controller.
// Streams ROM bytes [start..end] over a valid/ready handshake, then optionally
// the result word as upper-case hex ASCII, MSB nibble first.
// Optional feature macro: IS_MSG_TX_CRLF_EN (adds the CR, LF trailer to every transfer).
module is_msg_tx #(
    parameter int MEM_WIDTH = 8,
    parameter int RES_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 start_i,
    input  logic [MEM_WIDTH-1:0] start_addr_i,
    input  logic [MEM_WIDTH-1:0] end_addr_i,
    input  logic                 res_flg_i,
    input  logic [RES_W-1:0]     res_data_i,
    output logic [MEM_WIDTH-1:0] mem_addr_o,
    input  logic [7:0]           mem_data_i,
    output logic                 tx_valid_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_rdy_i,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int NDIG = RES_W / 4;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0]        TOP_IDX  = IW'(NDIG - 1);
    localparam logic [IW-1:0]        ONE_IDX  = IW'(1);
    localparam logic [MEM_WIDTH-1:0] ONE_ADDR = MEM_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SEND,
        S_HEX,
`ifdef IS_MSG_TX_CRLF_EN
        S_CR,
        S_LF,
`endif
        S_FIN
    } state_t;

    state_t               r_state;
    logic [MEM_WIDTH-1:0] r_mem_addr;
    logic [MEM_WIDTH-1:0] r_end;
    logic                 r_res_flg;
    logic [RES_W-1:0]     r_res;
    logic [IW-1:0]        r_dig_idx;
    logic                 r_tx_valid;
    logic [7:0]           r_tx_data;
    logic                 r_busy;
    logic                 r_done;

    logic [IW-1:0]        w_idx_dec;
    logic [3:0]           w_nib;
    logic [3:0]           w_nib_nxt;
    logic                 w_accept;

    // Nibble for the digit on display now and for the one that follows it,
    // so a new digit can be presented the cycle right after an accept.
    assign w_idx_dec = r_dig_idx - ONE_IDX;
    assign w_nib     = r_res[{r_dig_idx, 2'b00} +: 4];
    assign w_nib_nxt = r_res[{w_idx_dec, 2'b00} +: 4];
    assign w_accept  = r_tx_valid && tx_rdy_i;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        hex_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Main sequencer: one state register with all outputs registered alongside it.
    // The payload tail (last ROM byte / last digit / empty range) goes to the
    // CR/LF trailer when it is built, otherwise straight to FIN.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= S_IDLE;
            r_mem_addr <= '0;
            r_end      <= '0;
            r_res_flg  <= 1'b0;
            r_res      <= '0;
            r_dig_idx  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_mem_addr <= start_addr_i;
                        r_end      <= end_addr_i;
                        r_res_flg  <= res_flg_i;
                        r_res      <= res_data_i;
                        r_dig_idx  <= TOP_IDX;
                        r_busy     <= 1'b1;
                        if (end_addr_i >= start_addr_i) begin
                            r_state <= S_FETCH;
                        end else if (res_flg_i) begin
                            r_state <= S_HEX;
                        end else begin
`ifdef IS_MSG_TX_CRLF_EN
                            r_state <= S_CR;
`else
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
`endif
                        end
                    end
                end
                // ROM read issued on the address latched last cycle.
                S_FETCH: r_state <= S_WAIT;
                S_WAIT: begin
                    r_tx_data  <= mem_data_i;
                    r_tx_valid <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (w_accept) begin
                        r_tx_valid <= 1'b0;
                        // End compare happens before the increment, so an end
                        // address at the top of the ROM never wraps to zero.
                        if (r_mem_addr == r_end) begin
                            if (r_res_flg) begin
                                r_state <= S_HEX;
                            end else begin
`ifdef IS_MSG_TX_CRLF_EN
                                r_state <= S_CR;
`else
                                r_state <= S_FIN;
                                r_done  <= 1'b1;
`endif
                            end
                        end else begin
                            r_mem_addr <= r_mem_addr + ONE_ADDR;
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_HEX: begin
                    if (!r_tx_valid) begin
                        r_tx_data  <= hex_ascii(w_nib);
                        r_tx_valid <= 1'b1;
                    end else if (tx_rdy_i) begin
                        if (r_dig_idx == '0) begin
                            r_tx_valid <= 1'b0;
`ifdef IS_MSG_TX_CRLF_EN
                            r_state    <= S_CR;
`else
                            r_state    <= S_FIN;
                            r_done     <= 1'b1;
`endif
                        end else begin
                            r_dig_idx <= w_idx_dec;
                            r_tx_data <= hex_ascii(w_nib_nxt);
                        end
                    end
                end
`ifdef IS_MSG_TX_CRLF_EN
                S_CR: begin
                    if (!r_tx_valid) begin
                        r_tx_data  <= 8'h0D;
                        r_tx_valid <= 1'b1;
                    end else if (tx_rdy_i) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_LF;
                    end
                end
                S_LF: begin
                    if (!r_tx_valid) begin
                        r_tx_data  <= 8'h0A;
                        r_tx_valid <= 1'b1;
                    end else if (tx_rdy_i) begin
                        r_tx_valid <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_FIN;
                    end
                end
`endif
                // done_o is high during this state; busy_o falls on the way out.
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr_o = r_mem_addr;
    assign tx_valid_o = r_tx_valid;
    assign tx_data_o  = r_tx_data;
    assign busy_o     = r_busy;
    assign done_o     = r_done;

endmodule
